// File: rtl/sprite_pkg.sv
// Shared definitions for the per-scanline sprite evaluator: object word
// field layout, sprite heights, secondary-buffer fill value and FSM states.
package sprite_pkg;

   localparam int unsigned NUM_OBJECTS = 64;
   localparam int unsigned ADDR_W      = 6;
   localparam int unsigned MAX_SPRITES = 8;
   localparam int unsigned SEL_W       = 3;
   localparam int unsigned CNT_W       = SEL_W + 1;

   // Object word layout: {X[31:24], attr[23:16], tile[15:8], Y[7:0]}
   localparam int unsigned Y_LSB    = 0;
   localparam int unsigned Y_MSB    = 7;
   localparam int unsigned TILE_LSB = 8;
   localparam int unsigned TILE_MSB = 15;
   localparam int unsigned ATTR_LSB = 16;
   localparam int unsigned ATTR_MSB = 23;
   localparam int unsigned X_LSB    = 24;
   localparam int unsigned X_MSB    = 31;

   localparam int unsigned HEIGHT_8  = 8;
   localparam int unsigned HEIGHT_16 = 16;

   // Returned for secondary slots that hold no selected sprite
   localparam logic [31:0] SEC_FILL = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   // Secondary buffer entry: {X, attr, tile, 4'b0, row}
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] attr;
      logic [7:0] tile;
      logic [3:0] pad;
      logic [3:0] row;
   } sec_entry_t;

endpackage

// File: rtl/sprite_range_cmp.sv
// Vertical range test for one object against the target scanline.
//   scanline_i  : target scanline
//   y_i         : object top row
//   sprite_16_i : 0 = 8-row sprites, 1 = 16-row sprites
//   in_range_o  : object covers the scanline (no wrap-around)
//   row_o       : row within the sprite, scanline - Y
module sprite_range_cmp
   import sprite_pkg::*;
(
   input  logic [7:0] scanline_i,
   input  logic [7:0] y_i,
   input  logic       sprite_16_i,
   output logic       in_range_o,
   output logic [3:0] row_o
);

   logic [8:0] diff;
   logic [8:0] height;

   // A borrow (diff[8]) means Y is below the scanline: never in range
   always_comb begin
      diff       = {1'b0, scanline_i} - {1'b0, y_i};
      height     = sprite_16_i ? 9'(HEIGHT_16) : 9'(HEIGHT_8);
      in_range_o = ~diff[8] && (diff < height);
      row_o      = diff[3:0];
   end

endmodule

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluator. On start it reads all objects from the
// object attribute memory in index order and keeps the first MAX_SPRITES
// that cover the requested scanline in a secondary buffer.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin evaluation (ignored unless idle)
//   scanline,sprite_16: evaluation parameters, sampled on accepted start
//   oam_en/rw/addr    : object memory read port; oam_data arrives 1 cycle later
//   busy, done        : evaluation in progress / one-cycle completion pulse
//   sprite_count, overflow, sprite0_in : selection results
//   sec_rd_addr/data  : secondary buffer read port, 1-cycle latency
module sprite_eval
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        scanline,
   input  logic              sprite_16,
   output logic              oam_en,
   output logic              oam_rw,
   output logic [ADDR_W-1:0] oam_addr,
   input  logic [31:0]       oam_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sprite_count,
   output logic              overflow,
   output logic              sprite0_in,
   input  logic [SEL_W-1:0]  sec_rd_addr,
   output logic [31:0]       sec_rd_data
);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    en_q, en_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [7:0]              line_q;
   logic                    s16_q;
   logic                    cmp_vld_q;
   logic [ADDR_W-1:0]       cmp_idx_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    s0_q, s0_d;
   logic [MAX_SPRITES-1:0]  valid_q, valid_d;
   sec_entry_t              buf_q [MAX_SPRITES];
   logic                    wr_en;
   logic [SEL_W-1:0]        wr_idx;
   sec_entry_t              wr_entry;
   logic [31:0]             rd_q;
   logic                    accept;
   logic                    in_range;
   logic [3:0]              row;

   assign accept = (state_q == ST_IDLE) && start;

   sprite_range_cmp u_cmp (
      .scanline_i  (line_q),
      .y_i         (oam_data[Y_MSB:Y_LSB]),
      .sprite_16_i (s16_q),
      .in_range_o  (in_range),
      .row_o       (row)
   );

   // Sequencer: issues addresses 0..63, holds enable through DRAIN, pulses done in FIN
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               addr_d  = '0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_SCAN: begin
            en_d   = 1'b1;
            busy_d = 1'b1;
            if (addr_q == ADDR_W'(NUM_OBJECTS - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            state_d = ST_FIN;
            done_d  = 1'b1;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Evaluation parameters and the one-cycle-delayed compare slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q    <= '0;
         s16_q     <= 1'b0;
         cmp_vld_q <= 1'b0;
         cmp_idx_q <= '0;
      end else begin
         if (accept) begin
            line_q <= scanline;
            s16_q  <= sprite_16;
         end
         cmp_vld_q <= (state_q == ST_SCAN);
         cmp_idx_q <= addr_q;
      end
   end

   // Selection: first MAX_SPRITES hits fill the buffer, further hits flag overflow
   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      s0_d     = s0_q;
      valid_d  = valid_q;
      wr_en    = 1'b0;
      wr_idx   = cnt_q[SEL_W-1:0];
      wr_entry = '{x:    oam_data[X_MSB:X_LSB],
                   attr: oam_data[ATTR_MSB:ATTR_LSB],
                   tile: oam_data[TILE_MSB:TILE_LSB],
                   pad:  4'b0,
                   row:  row};
      if (accept) begin
         cnt_d   = '0;
         ovf_d   = 1'b0;
         s0_d    = 1'b0;
         valid_d = '0;
      end else if (cmp_vld_q && in_range) begin
         if (cnt_q < CNT_W'(MAX_SPRITES)) begin
            wr_en           = 1'b1;
            valid_d[wr_idx] = 1'b1;
            cnt_d           = cnt_q + 1'b1;
            if (cmp_idx_q == '0) begin
               s0_d = 1'b1;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         s0_q    <= 1'b0;
         valid_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         s0_q    <= s0_d;
         valid_q <= valid_d;
      end
   end

   // Entry storage needs no reset: every read is gated by its valid bit
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_idx] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= SEC_FILL;
      end else begin
         rd_q <= valid_q[sec_rd_addr] ? buf_q[sec_rd_addr] : SEC_FILL;
      end
   end

   assign oam_en       = en_q;
   assign oam_rw       = 1'b0;
   assign oam_addr     = addr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sprite_count = cnt_q;
   assign overflow     = ovf_q;
   assign sprite0_in   = s0_q;
   assign sec_rd_data  = rd_q;

endmodule

// File: doc/sprite_eval.md
Name: sprite_eval

Overview:
- Per-scanline sprite evaluator that sits directly downstream of the 64-entry object attribute memory.
- On a start pulse it scans all objects in index order and selects the first MAX_SPRITES objects whose vertical extent covers the requested scanline.
- It stores them in an internal secondary buffer, and the pattern-fetch/render stage reads that buffer.
- It also flags sprite-overflow and whether object 0 was selected.

Parameters:
- NUM_OBJECTS, 64, objects scanned per evaluation; must equal 2**ADDR_W.
- ADDR_W, 6, object index width.
- MAX_SPRITES, 8, secondary buffer depth; power of two.
- SEL_W, 3, log2(MAX_SPRITES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an evaluation; ignored while busy=1.
- scanline  in  8  target scanline; sampled on the accepted start cycle.
- sprite_16  in  1  0 = 8-row sprites, 1 = 16-row sprites; sampled with scanline.
- oam_en  out  1  object memory enable.
- oam_rw  out  1  object memory direction; tied to 0 (read).
- oam_addr  out  ADDR_W  object index to read.
- oam_data  in  32  object word {X[31:24], attr[23:16], tile[15:8], Y[7:0]}; registered, valid the cycle after the address is issued with oam_en=1.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse at the end of an evaluation.
- sprite_count  out  SEL_W+1  number of selected sprites, 0..MAX_SPRITES.
- overflow  out  1  more than MAX_SPRITES objects were in range.
- sprite0_in  out  1  object index 0 was selected.
- sec_rd_addr  in  SEL_W  secondary buffer read index.
- sec_rd_data  out  32  entry {X, attr, tile, 4'b0, row[3:0]}; registered, 1-cycle latency.

Behaviour:
- Reset (rst=1, asynchronous):
  - FSM goes to IDLE.
  - busy, done, oam_en, overflow and sprite0_in are 0; sprite_count is 0; oam_addr is 0; sec_rd_data is 32'hFFFFFFFF.
  - All secondary-buffer valid bits are cleared.
  - Reset mid-scan aborts the scan and no done pulse is issued.
- FSM states IDLE, SCAN, DRAIN, FIN:
  - IDLE: on start, latch scanline and sprite_16; clear count, overflow, sprite0_in and valid bits; go to SCAN with oam_addr=0, oam_en=1, busy=1.
  - SCAN: oam_addr increments every cycle. At oam_addr == NUM_OBJECTS-1, go to DRAIN.
  - DRAIN: one cycle with oam_en=1 held so the last registered read is not tri-stated. Compare the final object.
  - FIN: done=1 for exactly one cycle, busy falls, oam_en=0. Then return to IDLE.
  - oam_en stays 1 for the whole of SCAN and DRAIN. The object memory drives Z when disabled, so its output is never sampled while oam_en=0.
- Pipeline: the compare for object i uses oam_data in the cycle after address i was issued. The compare index is a one-cycle-delayed copy of oam_addr.
- Latency: start accepted at cycle 0; addresses issued in cycles 1..64; compares in cycles 2..65; done=1 in cycle 66. Latency is fixed regardless of hits.
- Range test:
  - diff = {1'b0, scanline} - {1'b0, Y}, 9-bit unsigned.
  - The object is in range iff diff[8]==0 and diff < (sprite_16 ? 16 : 8).
  - There is no wrap-around: Y > scanline is never in range. row = diff[3:0].
- Selection:
  - An in-range object with count < MAX_SPRITES is written at index count with its valid bit set; count increments. Index-0 hits set sprite0_in.
  - An in-range object with count == MAX_SPRITES sets overflow. count saturates.
- Outputs during and after a scan:
  - sprite_count, overflow and sprite0_in update live during SCAN.
  - They are final and stable from the done cycle until the next accepted start.
- Buffer reads:
  - sec_rd_data returns the entry at sec_rd_addr when its valid bit is set, otherwise 32'hFFFFFFFF.
  - Reads are allowed at any time; a read during a scan returns the current partial contents.
- start asserted while busy or in the FIN cycle is ignored. start in the cycle after FIN is accepted.

Decomposition:
- Package sprite_pkg holds:
  - OAM field bit ranges (Y, TILE, ATTR, X).
  - Sprite heights 8/16.
  - The secondary-entry fill value 32'hFFFFFFFF.
  - FSM state encoding.
- One sub-module, sprite_range_cmp: combinational; takes scanline, Y and sprite_16; returns in_range and row[3:0].

Test Plan:
- All 64 objects Y=0xF0, scanline=10, sprite_16=0 -> done in cycle 66; count=0; overflow=0; sprite0_in=0; every sec_rd_data=FFFFFFFF.
- Object 0 = {X=0x20, attr=0x01, tile=0x05, Y=0x0A}, scanline=0x0D -> count=1; sprite0_in=1; entry0=0x20010503.
- Objects 3..12 Y=50, scanline=57, sprite_16=0 -> count=8; overflow=1; entries are objects 3..10 with row=7. With scanline=58 -> count=0.
- Object 5 Y=50, scanline=63: sprite_16=1 gives count=1, row=13; sprite_16=0 gives count=0. Object Y=60, scanline=59 -> not selected (no wrap).
- start pulsed again at cycle 30 of a scan -> ignored; done in cycle 66 only. Then start in cycle 67 -> accepted; second done in cycle 133.
- rst asserted mid-scan at cycle 20 -> busy=0, oam_en=0 and count=0 immediately; no done pulse; the next start gives correct results.
